// File: rtl/neureka_tcdm_responder_pkg.sv
// Shared types and limits for the NEUREKA TCDM responder.
package neureka_tcdm_responder_pkg;

    localparam int TCDM_RESP_MAX_LAT = 4;

    typedef struct packed {
        logic [31:0] add;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] data;
    } tcdm_req_t;

    typedef struct packed {
        logic [31:0] r_data;
        logic        r_valid;
    } tcdm_resp_t;

endpackage

// File: rtl/neureka_tcdm_responder_bank.sv
// Single-port byte-enabled SRAM bank with registered read and a LAT-deep
// read-data pipe, so data lines up with the top-level response pipe.
module neureka_tcdm_bank
    import neureka_tcdm_responder_pkg::*;
#(
    parameter int BANK_WORDS = 1024,
    parameter int LAT        = 1,
    parameter int RW         = $clog2(BANK_WORDS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [RW-1:0] row_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0]           mem_q [BANK_WORDS];
    logic [LAT-1:0][31:0]  pipe_q, pipe_d;

    // Byte-masked write at the end of the grant cycle; contents are never reset
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[row_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Stage 0 captures the read word, later stages just delay it
    always_comb begin
        pipe_d = pipe_q;
        pipe_d[0] = (en_i && !we_i) ? mem_q[row_i] : pipe_q[0];
        for (int i = 1; i < LAT; i++) pipe_d[i] = pipe_q[i-1];
    end

    // Read-data pipe register
    always_ff @(posedge clk_i) begin
        if (rst_i) pipe_q <= '0;
        else       pipe_q <= pipe_d;
    end

    assign rdata_o = pipe_q[LAT-1];

endmodule

// File: rtl/neureka_tcdm_responder.sv
// Multi-port TCDM responder: word-interleaved banks, per-bank round-robin
// arbitration, fixed-latency responses. Optional random grant stalls are
// enabled with the macro NEUREKA_TCDM_RESP_STALL_EN.
module neureka_tcdm_responder
    import neureka_tcdm_responder_pkg::*;
#(
    parameter int MP         = 8,
    parameter int NB         = 8,
    parameter int BANK_WORDS = 1024,
    parameter int LAT        = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [MP-1:0]   tcdm_req,
    output logic [MP-1:0]   tcdm_gnt,
    input  logic [MP*32-1:0] tcdm_add,
    input  logic [MP-1:0]   tcdm_wen,
    input  logic [MP*4-1:0] tcdm_be,
    input  logic [MP*32-1:0] tcdm_data,
    output logic [MP*32-1:0] tcdm_r_data,
    output logic [MP-1:0]   tcdm_r_valid
);

    localparam int LAT_C  = (LAT > TCDM_RESP_MAX_LAT) ? TCDM_RESP_MAX_LAT : ((LAT < 1) ? 1 : LAT);
    localparam int LOG_NB = $clog2(NB);
    localparam int BW     = (NB > 1) ? LOG_NB : 1;
    localparam int RW     = $clog2(BANK_WORDS);
    localparam int PW     = (MP > 1) ? $clog2(MP) : 1;

    tcdm_req_t             req_s  [MP];
    tcdm_resp_t            resp_s [MP];
    logic [MP-1:0][BW-1:0] port_bank;
    logic [MP-1:0][RW-1:0] port_row;
    logic [MP-1:0]         unused_add;
    logic [MP-1:0]         stall;
    logic [MP-1:0]         elig;
    logic [NB-1:0][MP-1:0] bank_oh;
    logic [NB-1:0][31:0]   bank_rdata;

    logic [LAT_C-1:0][MP-1:0]         vld_q, vld_d, rd_q, rd_d;
    logic [LAT_C-1:0][MP-1:0][BW-1:0] bid_q, bid_d;

    // Unpack flat ports and decode word address into bank / row (upper bits alias)
    always_comb begin
        for (int p = 0; p < MP; p++) begin
            req_s[p].add  = tcdm_add[32*p +: 32];
            req_s[p].wen  = tcdm_wen[p];
            req_s[p].be   = tcdm_be[4*p +: 4];
            req_s[p].data = tcdm_data[32*p +: 32];
            port_row[p]   = req_s[p].add[2+LOG_NB +: RW];
            port_bank[p]  = (NB > 1) ? req_s[p].add[2 +: BW] : '0;
            unused_add[p] = ^req_s[p].add;
        end
    end

`ifdef NEUREKA_TCDM_RESP_STALL_EN
    logic [MP-1:0][15:0] lfsr_q, lfsr_d;

    // Per-port Fibonacci LFSR (taps 16,14,13,11); low two bits zero masks the grant
    always_comb begin
        for (int p = 0; p < MP; p++) begin
            lfsr_d[p] = {lfsr_q[p][0] ^ lfsr_q[p][2] ^ lfsr_q[p][3] ^ lfsr_q[p][5],
                         lfsr_q[p][15:1]};
            stall[p]  = (lfsr_q[p][1:0] == 2'b00);
        end
    end

    // LFSR state, reseeded per port on reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < MP; p++) lfsr_q[p] <= 16'hACE1 ^ 16'(p);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign stall = '0;
`endif

    // Stalled ports and everything during reset are invisible to the arbiters
    assign elig = tcdm_req & ~stall & {MP{~rst_i}};

    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [MP-1:0] breq, oh;
        logic [PW-1:0] widx, ptr_q, ptr_d;
        logic          any;
        logic [31:0]   rdata;

        // Round-robin search from ptr over ports addressing this bank
        always_comb begin
            breq = '0;
            oh   = '0;
            widx = '0;
            any  = 1'b0;
            for (int p = 0; p < MP; p++) breq[p] = elig[p] && (port_bank[p] == BW'(b));
            for (int i = 0; i < MP; i++) begin
                if (!any && breq[(int'(ptr_q) + i) % MP]) begin
                    any  = 1'b1;
                    widx = PW'((int'(ptr_q) + i) % MP);
                    oh[(int'(ptr_q) + i) % MP] = 1'b1;
                end
            end
            ptr_d = ptr_q;
            if (any) ptr_d = (int'(widx) == MP - 1) ? '0 : widx + 1'b1;
        end

        // Arbiter pointer, only moves on a grant
        always_ff @(posedge clk_i) begin
            if (rst_i) ptr_q <= '0;
            else       ptr_q <= ptr_d;
        end

        neureka_tcdm_bank #(
            .BANK_WORDS (BANK_WORDS),
            .LAT        (LAT_C),
            .RW         (RW)
        ) i_bank (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .en_i    (any),
            .we_i    (~req_s[widx].wen),
            .be_i    (req_s[widx].be),
            .row_i   (port_row[widx]),
            .wdata_i (req_s[widx].data),
            .rdata_o (rdata)
        );

        assign bank_oh[b]    = oh;
        assign bank_rdata[b] = rdata;
    end

    // A port is granted when the arbiter of its bank picked it
    always_comb begin
        tcdm_gnt = '0;
        for (int b = 0; b < NB; b++) tcdm_gnt = tcdm_gnt | bank_oh[b];
    end

    // Per-port response pipe: valid, read flag and bank id travel with the access
    always_comb begin
        vld_d    = vld_q;
        rd_d     = rd_q;
        bid_d    = bid_q;
        vld_d[0] = tcdm_gnt;
        rd_d[0]  = tcdm_wen;
        bid_d[0] = port_bank;
        for (int i = 1; i < LAT_C; i++) begin
            vld_d[i] = vld_q[i-1];
            rd_d[i]  = rd_q[i-1];
            bid_d[i] = bid_q[i-1];
        end
    end

    // Response pipe register; reset drops in-flight responses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            rd_q  <= '0;
            bid_q <= '0;
        end else begin
            vld_q <= vld_d;
            rd_q  <= rd_d;
            bid_q <= bid_d;
        end
    end

    // Route bank data back; writes and idle slots return zero
    always_comb begin
        tcdm_r_data  = '0;
        tcdm_r_valid = '0;
        for (int p = 0; p < MP; p++) begin
            resp_s[p].r_valid = vld_q[LAT_C-1][p];
            resp_s[p].r_data  = (vld_q[LAT_C-1][p] && rd_q[LAT_C-1][p]) ?
                                bank_rdata[bid_q[LAT_C-1][p]] : '0;
            tcdm_r_valid[p]         = resp_s[p].r_valid;
            tcdm_r_data[32*p +: 32] = resp_s[p].r_data;
        end
    end

endmodule

// File: tb/tb_neureka_tcdm_responder.sv
// Directed bench for neureka_tcdm_responder (MP=8, NB=8, LAT=3).
module tb_neureka_tcdm_responder;

    localparam int MP  = 8;
    localparam int NB  = 8;
    localparam int LAT = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [MP-1:0]     req = '0;
    logic [MP-1:0]     gnt;
    logic [MP*32-1:0]  add = '0;
    logic [MP-1:0]     wen = '1;
    logic [MP*4-1:0]   be = '0;
    logic [MP*32-1:0]  data = '0;
    logic [MP*32-1:0]  r_data;
    logic [MP-1:0]     r_valid;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q [MP][$];

    neureka_tcdm_responder #(.MP(MP), .NB(NB), .BANK_WORDS(1024), .LAT(LAT)) dut (
        .clk_i(clk), .rst_i(rst), .tcdm_req(req), .tcdm_gnt(gnt), .tcdm_add(add),
        .tcdm_wen(wen), .tcdm_be(be), .tcdm_data(data), .tcdm_r_data(r_data),
        .tcdm_r_valid(r_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] val(input logic [31:0] a);
        return 32'hA5000000 | a;
    endfunction

    task automatic set_port(input int p, input logic r, input logic [31:0] a, input logic w,
                            input logic [3:0] b, input logic [31:0] d);
        req[p] = r; add[32*p +: 32] = a; wen[p] = w; be[4*p +: 4] = b; data[32*p +: 32] = d;
    endtask

    task automatic clr_all();
        req = '0; wen = '1; be = '0;
    endtask

    // Issue one transaction and report grant wait, response latency and data
    task automatic xact(input int p, input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, output int gw, output int rl, output logic [31:0] rd);
        gw = 0; rl = -1; rd = '0;
        @(negedge clk); set_port(p, 1'b1, a, w, b, d); #1;
        while (!gnt[p] && gw < 40) begin @(negedge clk); #1; gw++; end
        if (!gnt[p]) begin gw = -1; clr_all(); return; end
        @(negedge clk); clr_all(); rl = 1;
        while (!r_valid[p] && rl < 12) begin @(negedge clk); rl++; end
        if (!r_valid[p]) rl = -1;
        rd = r_data[32*p +: 32];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int p = 0; p < MP; p++) set_port(p, 1'b1, 32'(4*p), 1'b1, 4'h0, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        tests_run++; if (gnt !== '0) begin tests_failed++; $display("FAIL reset_gnt: got %h want 00", gnt); end
        tests_run++; if (r_valid !== '0) begin tests_failed++; $display("FAIL reset_rvalid: got %h want 00", r_valid); end
        tests_run++; if (r_data !== '0) begin tests_failed++; $display("FAIL reset_rdata: got %h want 0", r_data); end
        @(negedge clk); rst = 1'b0; clr_all();
    endtask

    task automatic test_single();
        int gw, rl; logic [31:0] rd;
        xact(0, 32'h100, 1'b0, 4'hF, 32'hDEADBEEF, gw, rl, rd);
`ifndef NEUREKA_TCDM_RESP_STALL_EN
        tests_run++; if (gw !== 0) begin tests_failed++; $display("FAIL single_wr_gnt_wait: got %0d want 0", gw); end
`else
        tests_run++; if (gw < 0) begin tests_failed++; $display("FAIL single_wr_gnt_wait: got timeout want grant"); end
`endif
        tests_run++; if (rl !== LAT) begin tests_failed++; $display("FAIL single_wr_lat: got %0d want %0d", rl, LAT); end
        tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL single_wr_rdata: got %h want 0", rd); end
        xact(0, 32'h100, 1'b1, 4'h0, 32'h0, gw, rl, rd);
`ifndef NEUREKA_TCDM_RESP_STALL_EN
        tests_run++; if (gw !== 0) begin tests_failed++; $display("FAIL single_rd_gnt_wait: got %0d want 0", gw); end
`endif
        tests_run++; if (rl !== LAT) begin tests_failed++; $display("FAIL single_rd_lat: got %0d want %0d", rl, LAT); end
        tests_run++; if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL single_rd_data: got %h want deadbeef", rd); end
        @(negedge clk); #1;
        tests_run++; if (r_valid !== '0) begin tests_failed++; $display("FAIL single_rvalid_drop: got %h want 00", r_valid); end
        tests_run++; if (r_data !== '0) begin tests_failed++; $display("FAIL single_rdata_idle: got %h want 0", r_data); end
    endtask

    task automatic test_byte_en();
        int gw, rl; logic [31:0] rd;
        xact(1, 32'h200, 1'b0, 4'hF, 32'h11223344, gw, rl, rd);
        xact(1, 32'h200, 1'b0, 4'b0101, 32'hAABBCCDD, gw, rl, rd);
        xact(1, 32'h200, 1'b1, 4'h0, 32'h0, gw, rl, rd);
        tests_run++; if (rd !== 32'h11BB33DD) begin tests_failed++; $display("FAIL byte_en_merge: got %h want 11bb33dd", rd); end
        xact(1, 32'h200, 1'b0, 4'h0, 32'hFFFFFFFF, gw, rl, rd);
        tests_run++; if (rl !== LAT) begin tests_failed++; $display("FAIL be0_resp_lat: got %0d want %0d", rl, LAT); end
        xact(1, 32'h200, 1'b1, 4'h0, 32'h0, gw, rl, rd);
        tests_run++; if (rd !== 32'h11BB33DD) begin tests_failed++; $display("FAIL be0_noop: got %h want 11bb33dd", rd); end
    endtask

    task automatic test_full_bw();
        logic [MP*32-1:0] ev;
        for (int c = 0; c < 7 + LAT; c++) begin
            @(negedge clk);
            if (c == 0)     for (int p = 0; p < MP; p++) set_port(p, 1'b1, 32'(4*p), 1'b0, 4'hF, val(32'(4*p)));
            else if (c < 7) for (int p = 0; p < MP; p++) set_port(p, 1'b1, 32'(4*p), 1'b1, 4'h0, 32'h0);
            else            clr_all();
            #1;
            if (c < 7) begin
                tests_run++; if (gnt !== 8'hFF) begin tests_failed++; $display("FAIL full_bw_gnt c=%0d: got %h want ff", c, gnt); end
            end
            if (c >= LAT) begin
                ev = '0;
                if (c - LAT > 0) for (int p = 0; p < MP; p++) ev[32*p +: 32] = val(32'(4*p));
                tests_run++; if (r_valid !== 8'hFF) begin tests_failed++; $display("FAIL full_bw_rvalid c=%0d: got %h want ff", c, r_valid); end
                tests_run++; if (r_data !== ev) begin tests_failed++; $display("FAIL full_bw_rdata c=%0d: got %h want %h", c, r_data, ev); end
            end
        end
    endtask

    task automatic test_conflict();
        int gw, rl; logic [31:0] rd;
        logic [MP-1:0] eg;
        logic [MP*32-1:0] ev;
        int k;
        for (int q = 1; q < 4; q++) xact(0, 32'(32'h20 * q), 1'b0, 4'hF, val(32'(32'h20 * q)), gw, rl, rd);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 8 + LAT; c++) begin
            @(negedge clk);
            if (c < 8) for (int q = 0; q < 4; q++) set_port(q, 1'b1, 32'(32'h20 * q), 1'b1, 4'h0, 32'h0);
            else       clr_all();
            #1;
            if (c < 8) begin
                eg = '0; eg[c % 4] = 1'b1;
                tests_run++; if (gnt !== eg) begin tests_failed++; $display("FAIL conflict_gnt c=%0d: got %h want %h", c, gnt, eg); end
            end
            if (c >= LAT) begin
                k = (c - LAT) % 4;
                eg = '0; eg[k] = 1'b1;
                ev = '0; ev[32*k +: 32] = val(32'(32'h20 * k));
                tests_run++; if (r_valid !== eg) begin tests_failed++; $display("FAIL conflict_rvalid c=%0d: got %h want %h", c, r_valid, eg); end
                tests_run++; if (r_data !== ev) begin tests_failed++; $display("FAIL conflict_rdata c=%0d: got %h want %h", c, r_data, ev); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        int bad = 0;
        @(negedge clk); set_port(1, 1'b1, 32'h20, 1'b1, 4'h0, 32'h0); #1;
        tests_run++; if (gnt !== 8'b0000_0010) begin tests_failed++; $display("FAIL midflight_gnt: got %h want 02", gnt); end
        @(negedge clk); clr_all(); rst = 1'b1; set_port(0, 1'b1, 32'h0, 1'b1, 4'h0, 32'h0); #1;
        tests_run++; if (gnt !== '0) begin tests_failed++; $display("FAIL midflight_gnt_in_reset: got %h want 00", gnt); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 1) begin rst = 1'b0; clr_all(); end
            #1;
            if (r_valid !== '0) bad++;
        end
        tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL midflight_dropped: got %0d stray r_valid cycles want 0", bad); end
        @(negedge clk);
        for (int q = 0; q < 4; q++) set_port(q, 1'b1, 32'(32'h20 * q), 1'b1, 4'h0, 32'h0);
        #1;
        tests_run++; if (gnt !== 8'b0000_0001) begin tests_failed++; $display("FAIL midflight_ptr_reset: got %h want 01", gnt); end
        @(negedge clk); clr_all();
        repeat (LAT + 1) @(negedge clk);
    endtask

    task automatic test_stall();
        int wcnt[MP], rcnt[MP];
        logic [2:0] row[MP];
        int n_req = 0, n_stall = 0, n_gnt = 0, n_rv = 0, bad = 0, drain = 0, cyc;
        logic any_req;
        logic [31:0] a, e;
        for (int p = 0; p < MP; p++) begin wcnt[p] = 0; rcnt[p] = 0; row[p] = 3'($urandom_range(0, 7)); end
        for (cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < MP; p++) begin
                if (r_valid[p]) begin
                    n_rv++;
                    if (exp_q[p].size() == 0) bad++;
                    else begin
                        e = exp_q[p].pop_front();
                        tests_run++;
                        if (r_data[32*p +: 32] !== e) begin tests_failed++; $display("FAIL stall_rdata p=%0d: got %h want %h", p, r_data[32*p +: 32], e); end
                    end
                end
            end
            any_req = 1'b0;
            for (int p = 0; p < MP; p++) begin
                if (wcnt[p] < 8) begin
                    a = 32'((wcnt[p] * NB + p) * 4);
                    set_port(p, 1'b1, a, 1'b0, 4'hF, val(a)); any_req = 1'b1;
                end else if (rcnt[p] < 125) begin
                    a = 32'((int'(row[p]) * NB + p) * 4);
                    set_port(p, 1'b1, a, 1'b1, 4'h0, 32'h0); any_req = 1'b1;
                end else req[p] = 1'b0;
            end
            #1;
            for (int p = 0; p < MP; p++) begin
                if (req[p]) begin
                    n_req++;
                    if (gnt[p]) begin
                        n_gnt++;
                        if (!wen[p]) begin exp_q[p].push_back(32'h0); wcnt[p]++; end
                        else begin exp_q[p].push_back(val(add[32*p +: 32])); rcnt[p]++; row[p] = 3'($urandom_range(0, 7)); end
                    end else n_stall++;
                end
            end
            if (!any_req) drain++;
            if (drain > LAT + 1) break;
        end
        clr_all();
        tests_run++; if (cyc >= 6000) begin tests_failed++; $display("FAIL stall_timeout: got %0d cycles want completion", cyc); end
        tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL stall_unexpected_rvalid: got %0d want 0", bad); end
        tests_run++; if (n_rv !== n_gnt) begin tests_failed++; $display("FAIL stall_rvalid_count: got %0d want %0d", n_rv, n_gnt); end
        tests_run++; if (n_stall * 100 < n_req * 20 || n_stall * 100 > n_req * 30) begin
            tests_failed++; $display("FAIL stall_fraction: got %0d/%0d want 20-30 percent", n_stall, n_req); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_byte_en();
`ifdef NEUREKA_TCDM_RESP_STALL_EN
        test_stall();
`else
        test_full_bw();
        test_conflict();
        test_reset_midflight();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
